scroll_message_gen: RTL and testbench

Producer side of the 8-position character bus consumed by the multiplexed 7-segment driver. It holds a writable message of up to 32 character codes and presents an 8-character window (char7 leftmost … char0 rightmost) that advances one position every STEP_DIV clock cycles. This produces a scrolling marquee on the EGO1 dual-bank display. It sits between the top-level control/message-load logic and the display driver, in the same 1 kHz scan clock domain.

---
 rtl/scroll_message_gen.sv | 205 ++++++++++++++++++++
 tb/tb_scroll_message_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_message_gen.sv
// Scrolling marquee source for the 8-position 7-segment character bus.
// Define SCROLL_PAUSE_EN to hold the window for PAUSE_STEPS step periods after each wrap.
module scroll_message_gen #(
    parameter int unsigned STEP_DIV    = 500,
    parameter int unsigned PAUSE_STEPS = 4
) (
    input  logic       clk_scan,
    input  logic       rst,
    input  logic       en,
    input  logic       dir,
    input  logic [5:0] msg_len,
    input  logic       msg_we,
    input  logic [4:0] msg_addr,
    input  logic [4:0] msg_data,
    output logic [4:0] char0,
    output logic [4:0] char1,
    output logic [4:0] char2,
    output logic [4:0] char3,
    output logic [4:0] char4,
    output logic [4:0] char5,
    output logic [4:0] char6,
    output logic [4:0] char7,
    output logic       step_pulse,
    output logic       wrap
);

    localparam int DIV_W = $clog2(STEP_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [4:0] BLANK = 5'd16;

`ifdef SCROLL_PAUSE_EN
    localparam int unsigned PAUSE_CYC = PAUSE_STEPS * STEP_DIV;
    localparam int PCNT_W = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;
    localparam logic [PCNT_W-1:0] PAUSE_LAST = PCNT_W'(PAUSE_CYC - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    logic [PCNT_W-1:0] pcnt;
    logic [PCNT_W-1:0] pcnt_nx;
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif

    state_t           state;
    state_t           state_nx;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nx;
    logic [4:0]       pos;
    logic [4:0]       pos_nx;
    logic             step_nx;
    logic             wrap_nx;
    logic [5:0]       len;
    logic [4:0]       last;
    logic             pos_ok;
    logic [4:0]       msg [32];
    logic [4:0]       win [8];
    logic [4:0]       win_nx [8];

    always_comb begin
        len    = (msg_len > 6'd32) ? 6'd32 : msg_len;
        last   = 5'(len - 6'd1);
        pos_ok = (len != 6'd0) && ({1'b0, pos} < len);
    end

    // An out-of-range pos (len shrank or is zero) snaps to 0 in every state and never steps.
    always_comb begin
        state_nx = state;
        div_nx   = div;
        pos_nx   = pos;
        step_nx  = 1'b0;
        wrap_nx  = 1'b0;
`ifdef SCROLL_PAUSE_EN
        pcnt_nx  = pcnt;
`endif
        if (!pos_ok) begin
            pos_nx = 5'd0;
        end
        case (state)
            IDLE: begin
                div_nx = '0;
                if (en) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nx = IDLE;
                    div_nx   = '0;
                end else if (div == DIV_LAST) begin
                    div_nx = '0;
                    if (pos_ok) begin
                        step_nx = 1'b1;
                        if (!dir) begin
                            if (pos == last) begin
                                pos_nx  = 5'd0;
                                wrap_nx = 1'b1;
                            end else begin
                                pos_nx = pos + 5'd1;
                            end
                        end else begin
                            if (pos == 5'd0) begin
                                pos_nx  = last;
                                wrap_nx = 1'b1;
                            end else begin
                                pos_nx = pos - 5'd1;
                            end
                        end
`ifdef SCROLL_PAUSE_EN
                        if (wrap_nx && PAUSE_STEPS > 0) begin
                            state_nx = PAUSE;
                            pcnt_nx  = '0;
                        end
`endif
                    end
                end else begin
                    div_nx = div + DIV_W'(1);
                end
            end
`ifdef SCROLL_PAUSE_EN
            PAUSE: begin
                div_nx = '0;
                if (!en) begin
                    state_nx = IDLE;
                end else if (pcnt == PAUSE_LAST) begin
                    state_nx = RUN;
                end else begin
                    pcnt_nx = pcnt + PCNT_W'(1);
                end
            end
`endif
            default: begin
                state_nx = IDLE;
                div_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_scan) begin
        if (rst) begin
            state      <= IDLE;
            div        <= '0;
            pos        <= 5'd0;
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
`ifdef SCROLL_PAUSE_EN
            pcnt       <= '0;
`endif
        end else begin
            state      <= state_nx;
            div        <= div_nx;
            pos        <= pos_nx;
            step_pulse <= step_nx;
            wrap       <= wrap_nx;
`ifdef SCROLL_PAUSE_EN
            pcnt       <= pcnt_nx;
`endif
        end
    end

    // Window indices wrap modulo len; short messages need several subtractions to tile.
    always_comb begin
        logic [5:0] base;
        logic [5:0] idx;
        win_nx = '{default: BLANK};
        base   = pos_ok ? {1'b0, pos} : 6'd0;
        idx    = 6'd0;
        for (int k = 0; k < 8; k++) begin
            idx = base + 6'(7 - k);
            for (int r = 0; r < 8; r++) begin
                if (len != 6'd0 && idx >= len) begin
                    idx = idx - len;
                end
            end
            win_nx[k] = (len == 6'd0) ? BLANK : msg[idx[4:0]];
        end
    end

    always_ff @(posedge clk_scan) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                msg[i] <= BLANK;
            end
            for (int k = 0; k < 8; k++) begin
                win[k] <= BLANK;
            end
        end else begin
            if (msg_we) begin
                msg[msg_addr] <= msg_data;
            end
            for (int k = 0; k < 8; k++) begin
                win[k] <= win_nx[k];
            end
        end
    end

    assign char0 = win[0];
    assign char1 = win[1];
    assign char2 = win[2];
    assign char3 = win[3];
    assign char4 = win[4];
    assign char5 = win[5];
    assign char6 = win[6];
    assign char7 = win[7];

endmodule

// File: tb/tb_scroll_message_gen.sv
// Scoreboard bench for scroll_message_gen: stimulus queues expected steps, a monitor checks each step_pulse.
module tb_scroll_message_gen;

    localparam int STEP = 4;
    localparam int PSTEPS = 2;
`ifdef SCROLL_PAUSE_EN
    localparam int GAP_AFTER_WRAP = (PSTEPS + 1) * STEP;
`else
    localparam int GAP_AFTER_WRAP = STEP;
`endif

    logic       clk_scan = 1'b0;
    logic       rst;
    logic       en;
    logic       dir;
    logic [5:0] msg_len;
    logic       msg_we;
    logic [4:0] msg_addr;
    logic [4:0] msg_data;
    logic [4:0] char0, char1, char2, char3, char4, char5, char6, char7;
    logic       step_pulse;
    logic       wrap;

    typedef struct {
        int   gap;
        logic wrap;
        int   char7;
    } step_t;

    step_t sb[$];
    int    error_count = 0;
    int    check_count = 0;
    int    cyc = 0;
    int    mark = 0;
    bit    pend = 1'b0;
    int    pend_c7 = 0;
    int    hello[5] = '{10, 11, 13, 13, 0};

    scroll_message_gen #(
        .STEP_DIV   (STEP),
        .PAUSE_STEPS(PSTEPS)
    ) dut (
        .clk_scan  (clk_scan),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .msg_len   (msg_len),
        .msg_we    (msg_we),
        .msg_addr  (msg_addr),
        .msg_data  (msg_data),
        .char0     (char0),
        .char1     (char1),
        .char2     (char2),
        .char3     (char3),
        .char4     (char4),
        .char5     (char5),
        .char6     (char6),
        .char7     (char7),
        .step_pulse(step_pulse),
        .wrap      (wrap)
    );

    always #5 clk_scan = ~clk_scan;

    always @(posedge clk_scan) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkWindow(input string name, input logic [39:0] expv);
        logic [4:0] act [8];
        act = '{char0, char1, char2, char3, char4, char5, char6, char7};
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("%s_char%0d", name, k), int'(act[k]), int'(expv[k*5 +: 5]));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_scan);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic e, input logic d, input logic [5:0] l);
        if (e && !en) begin
            mark = cyc + 1;
        end
        en      = e;
        dir     = d;
        msg_len = l;
    endtask

    task automatic writeChar(input int addr, input int data);
        msg_we   = 1'b1;
        msg_addr = 5'(addr);
        msg_data = 5'(data);
        tick(1);
        msg_we   = 1'b0;
    endtask

    task automatic pushStep(input int gap, input logic w, input int c7);
        step_t s;
        s.gap   = gap;
        s.wrap  = w;
        s.char7 = c7;
        sb.push_back(s);
    endtask

    task automatic waitDrained(input int budget);
        int n = 0;
        while ((sb.size() != 0 || pend) && n < budget) begin
            tick(1);
            n++;
        end
        if (sb.size() != 0 || pend) begin
            checkOutput("drain_timeout_pending_steps", sb.size(), 0);
            sb.delete();
            pend = 1'b0;
        end
    endtask

    // Monitor: every step_pulse must match the next queued step; char7 is checked one cycle later.
    always @(negedge clk_scan) begin
        step_t e;
        if (pend) begin
            checkOutput("char7_after_step", int'(char7), pend_c7);
            pend = 1'b0;
        end
        if (step_pulse === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_step", int'(step_pulse), 0);
            end else begin
                e = sb.pop_front();
                checkOutput("step_gap", cyc - mark, e.gap);
                checkOutput("step_wrap", int'(wrap), int'(e.wrap));
                pend    = 1'b1;
                pend_c7 = e.char7;
            end
            mark = cyc;
        end else if (wrap === 1'b1) begin
            checkOutput("wrap_without_step", int'(wrap), 0);
        end
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        dir      = 1'b0;
        msg_len  = 6'd0;
        msg_we   = 1'b0;
        msg_addr = 5'd0;
        msg_data = 5'd0;
        tick(2);
        checkWindow("reset_window", {8{5'd16}});
        checkOutput("reset_step_pulse", int'(step_pulse), 0);
        checkOutput("reset_wrap", int'(wrap), 0);
        rst = 1'b0;

        applyStimulus(1'b0, 1'b0, 6'd5);
        for (int i = 0; i < 5; i++) begin
            writeChar(i, hello[i]);
        end
        tick(1);
        checkWindow("hello_window", {5'd10, 5'd11, 5'd13, 5'd13, 5'd0, 5'd10, 5'd11, 5'd13});
        tick(8);

        // dir=1 from pos 0 wraps to pos 4; en then drops (mid-pause when pausing is built in)
        pushStep(STEP, 1'b1, 0);
        applyStimulus(1'b1, 1'b1, 6'd5);
        waitDrained(40);
        applyStimulus(1'b0, 1'b1, 6'd5);
        tick(10);

        // dir=0 from pos 4: 0,1,2,3,4,0,1,2,3
        pushStep(STEP, 1'b1, 10);
        pushStep(GAP_AFTER_WRAP, 1'b0, 11);
        pushStep(STEP, 1'b0, 13);
        pushStep(STEP, 1'b0, 13);
        pushStep(STEP, 1'b0, 0);
        pushStep(STEP, 1'b1, 10);
        pushStep(GAP_AFTER_WRAP, 1'b0, 11);
        pushStep(STEP, 1'b0, 13);
        pushStep(STEP, 1'b0, 13);
        applyStimulus(1'b1, 1'b0, 6'd5);
        waitDrained(120);
        applyStimulus(1'b0, 1'b0, 6'd5);
        tick(3);

        // pos=3, shrink to len 2: pos snaps to 0 and the window tiles
        applyStimulus(1'b0, 1'b0, 6'd2);
        tick(2);
        checkWindow("tile_len2", {5'd10, 5'd11, 5'd10, 5'd11, 5'd10, 5'd11, 5'd10, 5'd11});
        pushStep(STEP, 1'b0, 11);
        applyStimulus(1'b1, 1'b0, 6'd2);
        waitDrained(40);
        applyStimulus(1'b0, 1'b0, 6'd2);
        tick(2);

        // len 1: every step wraps and pos stays 0
        applyStimulus(1'b0, 1'b0, 6'd1);
        tick(2);
        checkWindow("len1_window", {8{5'd10}});
        pushStep(STEP, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 6'd1);
        waitDrained(40);
        applyStimulus(1'b0, 1'b0, 6'd1);
        tick(2);

        // len 0: blank window, no steps even while enabled
        applyStimulus(1'b0, 1'b0, 6'd0);
        tick(2);
        checkWindow("len0_window", {8{5'd16}});
        applyStimulus(1'b1, 1'b0, 6'd0);
        tick(12);
        applyStimulus(1'b0, 1'b0, 6'd0);
        tick(2);

        // reset mid-run with a simultaneous write: reset wins
        applyStimulus(1'b1, 1'b0, 6'd5);
        tick(2);
        rst      = 1'b1;
        en       = 1'b0;
        msg_we   = 1'b1;
        msg_addr = 5'd0;
        msg_data = 5'd7;
        tick(1);
        rst    = 1'b0;
        msg_we = 1'b0;
        checkWindow("rst_window", {8{5'd16}});
        checkOutput("rst_step_pulse", int'(step_pulse), 0);
        checkOutput("rst_wrap", int'(wrap), 0);
        tick(2);
        checkWindow("rst_buffer_blank", {8{5'd16}});
        tick(10);

        writeChar(0, 12);
        tick(1);
        checkWindow("post_rst_write", {5'd12, 5'd16, 5'd16, 5'd16, 5'd16, 5'd12, 5'd16, 5'd16});
        tick(2);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
